// File: rtl/pam_4_pkg.sv
// Shared types and helpers for the PAM-4 receive path.
// Symbol coding is Gray-free: 00 is the most negative level.
package pam_4_pkg;

  typedef logic [1:0] pam4_sym_t;

  localparam pam4_sym_t SYM_M3 = 2'b00;
  localparam pam4_sym_t SYM_M1 = 2'b01;
  localparam pam4_sym_t SYM_P1 = 2'b10;
  localparam pam4_sym_t SYM_P3 = 2'b11;

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  function automatic int threshold(
    input int sep,
    input int k
  );
    return sep * k;
  endfunction

endpackage

// File: rtl/pam_4_slicer.sv
// Registered mid-point slicer with clip detection.
// Thresholds are compared in widened signed arithmetic.
module pam_4_slicer
  import pam_4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] sample_in,
  input  logic                         sample_in_valid,
  output pam4_sym_t                    sym,
  output logic                         sym_valid,
  output logic                         clip
);

  localparam int W  = SIGNAL_RESOLUTION;
  localparam int TP = threshold(SYMBOL_SEPERATION, 1);
  localparam int TN = -TP;
  localparam int CP = threshold(SYMBOL_SEPERATION, 2);
  localparam int CN = -CP;

  localparam logic signed [W:0]   T_P  = TP[W:0];
  localparam logic signed [W:0]   T_N  = TN[W:0];
  localparam logic signed [W:0]   ZERO = '0;
  localparam logic signed [W+1:0] C_P  = CP[W+1:0];
  localparam logic signed [W+1:0] C_N  = CN[W+1:0];

  logic signed [W:0]   s_t;
  logic signed [W+1:0] s_c;
  pam4_sym_t           sym_d;
  logic                clip_d;

  assign s_t = {sample_in[W-1], sample_in};
  assign s_c = {{2{sample_in[W-1]}}, sample_in};

  always_comb begin
    sym_d = SYM_P3;
    unique case (1'b1)
      (s_t < T_N):                 sym_d = SYM_M3;
      (s_t >= T_N && s_t < ZERO):  sym_d = SYM_M1;
      (s_t >= ZERO && s_t < T_P):  sym_d = SYM_P1;
      default:                     sym_d = SYM_P3;
    endcase
  end

  assign clip_d = (s_c >= C_P) || (s_c <= C_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym       <= SYM_M3;
      sym_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      sym_valid <= sample_in_valid;
      clip      <= sample_in_valid & clip_d;
      if (sample_in_valid) begin
        sym <= sym_d;
      end
    end
  end

endmodule

// File: rtl/pam_4_slicer_deser.sv
// PAM-4 receive slicer, LSB-first word packer and one-entry
// output buffer with saturating clip/overflow statistics.
module pam_4_slicer_deser
  import pam_4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int WORD_SYMBOLS      = 4,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] sample_in,
  input  logic                         sample_in_valid,
  input  logic                         resync,
  input  logic                         clr_counts,
  output logic [2*WORD_SYMBOLS-1:0]    word_out,
  output logic                         word_out_valid,
  input  logic                         word_out_ready,
  output logic [CNT_WIDTH-1:0]         clip_count,
  output logic [CNT_WIDTH-1:0]         overflow_count
);

  localparam int WW = 2 * WORD_SYMBOLS;
  localparam int IW = $clog2(WORD_SYMBOLS);
  localparam logic [IW-1:0] LAST = IW'(WORD_SYMBOLS - 1);

  pam4_sym_t   sym;
  logic        sym_valid;
  logic        clip;

  logic [IW-1:0] idx;
  logic [IW-1:0] ib;
  logic [WW-1:0] shift_q;
  logic [WW-1:0] word_new;
  logic          complete;

  buf_state_t state, next_state;
  logic       load;
  logic       drop;

  pam_4_slicer #(
    .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION (SYMBOL_SEPERATION)
  ) u_slicer (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sym             (sym),
    .sym_valid       (sym_valid),
    .clip            (clip)
  );

  // resync restarts the word, so a coinciding symbol lands in slot 0
  always_comb begin
    ib       = resync ? '0 : idx;
    word_new = resync ? '0 : shift_q;
    word_new[2*int'(ib) +: 2] = sym;
    complete = sym_valid && (ib == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      shift_q <= '0;
    end else if (sym_valid) begin
      if (complete) begin
        idx     <= '0;
        shift_q <= '0;
      end else begin
        idx     <= ib + 1'b1;
        shift_q <= word_new;
      end
    end else if (resync) begin
      idx     <= '0;
      shift_q <= '0;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    drop       = 1'b0;
    unique case (state)
      BUF_EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          next_state = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (word_out_ready) begin
          if (complete) begin
            load = 1'b1;
          end else begin
            next_state = BUF_EMPTY;
          end
        end else if (complete) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BUF_EMPTY;
      word_out <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        word_out <= word_new;
      end
    end
  end

  assign word_out_valid = (state == BUF_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count     <= '0;
      overflow_count <= '0;
    end else if (clr_counts) begin
      clip_count     <= '0;
      overflow_count <= '0;
    end else begin
      if (clip && clip_count != '1) begin
        clip_count <= clip_count + 1'b1;
      end
      if (drop && overflow_count != '1) begin
        overflow_count <= overflow_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pam_4_slicer_deser.sv
// Scoreboard bench for the PAM-4 slicer/deserializer.
// A second instance with narrow counters exercises saturation.
module tb_pam_4_slicer_deser;

  localparam int SEP = 56;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       resync;
  logic       clr_counts;
  logic [7:0] word_out;
  logic       word_out_valid;
  logic       word_out_ready;
  logic [15:0] clip_count;
  logic [15:0] overflow_count;

  logic [7:0] sat_sample;
  logic       sat_valid;
  logic       sat_resync;
  logic       sat_clr;
  logic [7:0] sat_word;
  logic       sat_word_valid;
  logic       sat_ready;
  logic [3:0] sat_clip;
  logic [3:0] sat_ovf;

  always #5 clk = ~clk;

  pam_4_slicer_deser u_dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .resync          (resync),
    .clr_counts      (clr_counts),
    .word_out        (word_out),
    .word_out_valid  (word_out_valid),
    .word_out_ready  (word_out_ready),
    .clip_count      (clip_count),
    .overflow_count  (overflow_count)
  );

  pam_4_slicer_deser #(
    .CNT_WIDTH (4)
  ) u_sat (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sat_sample),
    .sample_in_valid (sat_valid),
    .resync          (sat_resync),
    .clr_counts      (sat_clr),
    .word_out        (sat_word),
    .word_out_valid  (sat_word_valid),
    .word_out_ready  (sat_ready),
    .clip_count      (sat_clip),
    .overflow_count  (sat_ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  logic [7:0] m_word;
  logic [7:0] last_word;
  int         m_n;
  int         exp_clip;
  int         exp_ovf;
  bit         push_en;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_sym(input int s);
    if (s < -SEP) return 2'b00;
    if (s < 0) return 2'b01;
    if (s < SEP) return 2'b10;
    return 2'b11;
  endfunction

  function automatic bit exp_is_clip(input int s);
    return (s >= 2 * SEP) || (s <= -2 * SEP);
  endfunction

  task automatic feed(input int s);
    @(posedge clk);
    #1;
    sample_in       = 8'(s);
    sample_in_valid = 1'b1;
    resync          = 1'b0;
    m_word[2*m_n +: 2] = exp_sym(s);
    m_n++;
    if (exp_is_clip(s)) exp_clip++;
    if (m_n == 4) begin
      last_word = m_word;
      if (push_en) sb_q.push_back(m_word);
      m_n = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample_in_valid = 1'b0;
      resync          = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && word_out_valid && word_out_ready) begin
      if (sb_q.size() == 0)
        chk("sb_underflow", sb_q.size(), 1);
      else
        chk("word", word_out, sb_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    resync          = 1'b0;
    clr_counts      = 1'b0;
    word_out_ready  = 1'b1;
    sat_sample      = '0;
    sat_valid       = 1'b0;
    sat_resync      = 1'b0;
    sat_clr         = 1'b0;
    sat_ready       = 1'b1;
    m_word          = '0;
    last_word       = '0;
    m_n             = 0;
    exp_clip        = 0;
    exp_ovf         = 0;
    push_en         = 1'b1;

    #12;
    chk("rst_word", word_out, 0);
    chk("rst_valid", word_out_valid, 0);
    chk("rst_clip", clip_count, 0);
    chk("rst_ovf", overflow_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic word and latency
    feed(84);
    feed(-84);
    feed(28);
    feed(-28);
    chk("model_63", last_word, 8'h63);
    idle(1);
    @(negedge clk);
    chk("lat_n1", word_out_valid, 0);
    @(negedge clk);
    chk("lat_n2", word_out_valid, 1);
    @(negedge clk);
    chk("lat_n3", word_out_valid, 0);
    idle(2);

    // threshold edges and clip detection
    feed(-57); feed(-56); feed(-1); feed(0);
    feed(55); feed(56); feed(111);
    idle(3);
    chk("clip_111", clip_count, exp_clip);
    feed(112);
    idle(3);
    chk("clip_112", clip_count, exp_clip);
    feed(-112); feed(-128); feed(0); feed(0);
    idle(4);
    chk("clip_total", clip_count, exp_clip);
    chk("clip_three", clip_count, 3);

    // backpressure: first word held, next two dropped
    word_out_ready = 1'b0;
    push_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      feed(((i * 37) % 200) - 100);
      if (i == 3) begin
        m_word = last_word;
        sb_q.push_back(last_word);
      end
      if (i == 8) begin
        @(negedge clk);
        chk("hold_mid", word_out, sb_q[0]);
      end
    end
    exp_ovf += 2;
    idle(4);
    chk("hold_valid", word_out_valid, 1);
    chk("hold_end", word_out, sb_q[0]);
    chk("ovf_two", overflow_count, exp_ovf);
    @(posedge clk);
    #1;
    word_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("one_xfer", word_out_valid, 0);
    chk("sb_drain1", sb_q.size(), 0);
    push_en = 1'b1;

    // resync aligned with the third symbol
    feed(10);
    feed(-10);
    m_n = 0;
    m_word = '0;
    feed(28);
    @(posedge clk);
    #1;
    sample_in_valid = 1'b0;
    resync          = 1'b1;
    feed(84);
    feed(-28);
    feed(-84);
    chk("model_1e", last_word, 8'h1e);
    idle(4);
    chk("sb_drain2", sb_q.size(), 0);

    // async reset mid-word with a held word
    word_out_ready = 1'b0;
    push_en = 1'b0;
    feed(20); feed(-20); feed(70); feed(-70);
    feed(5); feed(-5);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_word", word_out, 0);
    chk("arst_valid", word_out_valid, 0);
    chk("arst_clip", clip_count, 0);
    chk("arst_ovf", overflow_count, 0);
    @(negedge clk);
    sample_in_valid = 1'b0;
    rst = 1'b0;
    word_out_ready = 1'b1;
    m_n = 0;
    m_word = '0;
    exp_clip = 0;
    push_en = 1'b1;
    feed(-100); feed(100); feed(-30); feed(30);
    idle(4);
    chk("post_rst_drain", sb_q.size(), 0);

    // saturation and clear priority on the narrow instance
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      sat_sample = 8'd120;
      sat_valid  = 1'b1;
    end
    @(posedge clk);
    #1;
    sat_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", sat_clip, 15);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_clr", sat_clip, 0);
    sat_valid = 1'b1;
    @(posedge clk);
    #1;
    sat_valid = 1'b0;
    sat_clr   = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_wins", sat_clip, 0);
    sat_valid = 1'b1;
    @(posedge clk);
    #1;
    sat_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clip_after_clr", sat_clip, 1);

    chk("sb_final", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pam_4_slicer_deser.md
Name: pam_4_slicer_deser

Overview:
- Receive-side counterpart of the PAM-4 transmit path.
- Takes noisy signed channel samples and slices each one to a 2-bit symbol using mid-point thresholds.
- Packs symbols LSB-first into words and hands words downstream with a valid/ready handshake.
- Keeps saturating clip and overflow statistics for link-quality monitoring. Sits between the channel model output and the bit-error checker.

Parameters:
- SIGNAL_RESOLUTION, 8, sample width (two's-complement signed).
- SYMBOL_SEPERATION, 56, nominal spacing between adjacent PAM-4 levels; ideal levels are ±SEP/2 and ±(SEP+SEP/2).
- WORD_SYMBOLS, 4, symbols per output word; word width is 2*WORD_SYMBOLS; must be ≥2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- sample_in, input, SIGNAL_RESOLUTION, signed received sample.
- sample_in_valid, input, 1, sample qualifier; no backpressure toward the channel.
- resync, input, 1, single-cycle pulse; discards any partial word to realign word boundaries.
- clr_counts, input, 1, synchronous clear of both counters.
- word_out, output, 2*WORD_SYMBOLS, packed symbols; first received symbol sits in [1:0].
- word_out_valid, output, 1, word_out holds a valid word.
- word_out_ready, input, 1, downstream accepts the word.
- clip_count, output, CNT_WIDTH, saturating count of clipped samples.
- overflow_count, output, CNT_WIDTH, saturating count of dropped words.

Behaviour:
- Reset (async, rst=1): all registers 0, including word_out, word_out_valid, both counters, packer index and slicer stage.
- Slicer (stage 1, registered, 1 cycle). With s = signed sample and T = SEP:
  - s < -T gives 00.
  - -T ≤ s < 0 gives 01.
  - 0 ≤ s < T gives 10.
  - s ≥ T gives 11.
- Compare in SIGNAL_RESOLUTION+1 signed bits so thresholds cannot overflow.
- Clip detect (same stage): |s| ≥ 2*T increments clip_count by 1, saturating at all-ones. The most negative sample counts as clipped.
- Packer (stage 2):
  - Index 0..WORD_SYMBOLS-1. Each sliced symbol is written into shift slot [2*idx+1 : 2*idx] and idx increments.
  - When the symbol lands at idx = WORD_SYMBOLS-1, the word is complete and idx returns to 0.
- Output buffer: one-entry, two states.
  - EMPTY: a completed word loads word_out and the buffer goes to FULL (word_out_valid=1).
  - FULL:
    - word_out_ready=1 with no completion: go to EMPTY.
    - word_out_ready=1 with a completion in the same cycle: the new word replaces the old one and the buffer stays FULL (no bubble).
    - word_out_ready=0 with a completion: the new word is dropped, overflow_count increments (saturating), and word_out is unchanged.
- Handshake: transfer occurs when valid & ready. word_out stays stable while valid=1 and ready=0.
- Latency: a sample at cycle N completing a word makes word_out_valid=1 at N+2, provided the buffer is EMPTY or ready=1 at N+1.
- resync:
  - Clears idx and the partial shift contents at the next edge.
  - If resync and a sliced symbol coincide, the symbol becomes slot 0 of the new word.
  - resync never affects the output buffer, slicer stage, or counters.
- clr_counts: both counters go to 0. If an increment coincides, the clear wins.
- Invalid cycles (sample_in_valid=0): the slicer-stage valid drops and the packer holds.
- Reset asserted mid-word or mid-handshake: immediate clear, and the partial word is lost.

Decomposition:
- Package pam_4_pkg:
  - typedef pam4_sym_t (logic [1:0]).
  - Symbol constants SYM_M3=00, SYM_M1=01, SYM_P1=10, SYM_P3=11.
  - Function threshold(sep, k).
  - Output-buffer enum {BUF_EMPTY, BUF_FULL}.
- One sub-module: pam_4_slicer, the registered threshold, clip and valid stage.
- Packer, buffer and counters stay in the top module.

Test Plan:
- Defaults, samples 84,-84,28,-28 back-to-back with ready=1: word_out=8'h63 and valid exactly 1 cycle, 2 cycles after the last sample.
- Threshold edges -57,-56,-1,0,55,56 give symbols 00,01,01,10,10,11. Samples 111/112/-112/-128 increment clip_count by 0/1/1/1.
- Hold ready=0 while feeding 12 samples: the first word is held stable, words 2 and 3 are dropped, overflow_count=2. Raising ready then gives one transfer.
- Feed 2 samples, pulse resync together with the 3rd sample, then feed 3 more: the first word equals the 3rd to 6th symbols.
- Force a counter to saturate (CNT_WIDTH=4, 20 clips): it holds at 15. clr_counts coinciding with a clip gives 0.
- Assert rst asynchronously mid-word with valid=1 and ready=0: all outputs are 0 immediately, and the next 4 samples form a clean word.
